// File: rtl/delay_line_param_if.sv
// Bus bundle for delay_line_param: stream controls, sample in, delayed sample
// and status out. Clock and reset stay outside the bundle.
interface delay_line_param_if #(
  parameter int DWIDTH    = 8,
  parameter int MAX_DELAY = 31
);
  localparam int DELAY_W = $clog2(MAX_DELAY + 1);

  logic               en_i;
  logic               clr_i;
  logic [DWIDTH-1:0]  data_i;
  logic [DELAY_W-1:0] delay_i;
  logic [DWIDTH-1:0]  data_o;
  logic               valid_o;
  logic               delay_err_o;

  // Producer side: drives the stream and the delay request
  modport master (
    output en_i, clr_i, data_i, delay_i,
    input  data_o, valid_o, delay_err_o
  );

  // Delay line side
  modport slave (
    input  en_i, clr_i, data_i, delay_i,
    output data_o, valid_o, delay_err_o
  );
endinterface

// File: rtl/delay_line_param.sv
// Programmable delay line: delays a DWIDTH-bit word by 0..MAX_DELAY enabled
// cycles. Tracks how many real samples have entered since reset/flush so
// valid_o reports whether the selected tap holds genuine data. Requests above
// MAX_DELAY are clamped and flagged.
module delay_line_param #(
  parameter int DWIDTH    = 8,
  parameter int MAX_DELAY = 31
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  delay_line_param_if.slave    bus
);
  localparam int                 DELAY_W = $clog2(MAX_DELAY + 1);
  localparam logic [DELAY_W-1:0] MAX_D   = DELAY_W'(MAX_DELAY);

  logic [DWIDTH-1:0]  r_sr [1:MAX_DELAY];
  logic [DELAY_W-1:0] r_fill;
  logic [DELAY_W-1:0] w_d_eff;
  logic               w_over;
  logic [DWIDTH-1:0]  w_tap;

  // Out-of-range detection only exists when delay_i can encode values above MAX_DELAY
  generate
    if (MAX_DELAY == (2 ** DELAY_W) - 1) begin : g_no_over
      assign w_over = 1'b0;
    end else begin : g_over
      assign w_over = (bus.delay_i > MAX_D);
    end
  endgenerate

  assign w_d_eff = w_over ? MAX_D : bus.delay_i;

  // Tap chain: flush has priority over shifting; taps hold while disabled
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned k = 1; k <= MAX_DELAY; k++) r_sr[k] <= '0;
    end else if (bus.clr_i) begin
      for (int unsigned k = 1; k <= MAX_DELAY; k++) r_sr[k] <= '0;
    end else if (bus.en_i) begin
      r_sr[1] <= bus.data_i;
      for (int unsigned k = 2; k <= MAX_DELAY; k++) r_sr[k] <= r_sr[k-1];
    end
  end

  // Fill count of real samples in the line, saturating at MAX_DELAY
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_fill <= '0;
    end else if (bus.clr_i) begin
      r_fill <= '0;
    end else if (bus.en_i && (r_fill != MAX_D)) begin
      r_fill <= r_fill + 1'b1;
    end
  end

  // Tap select for the clamped delay; d_eff=0 is handled by the bypass below
  always_comb begin
    w_tap = '0;
    for (int unsigned k = 1; k <= MAX_DELAY; k++) begin
      if (w_d_eff == DELAY_W'(k)) w_tap = r_sr[k];
    end
  end

  assign bus.data_o      = (w_d_eff == '0) ? bus.data_i : w_tap;
  assign bus.valid_o     = (r_fill >= w_d_eff);
  assign bus.delay_err_o = w_over;
endmodule

// File: tb/tb_delay_line_param.sv
// Self-checking bench for delay_line_param: a 31-deep instance for the main
// scenarios and a 20-deep instance for clamp/error behaviour, both compared
// against a queue-based model of the delay line.
module tb_delay_line_param;
  localparam int M1 = 31;
  localparam int M2 = 20;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  delay_line_param_if #(.DWIDTH(8), .MAX_DELAY(M1)) b1 ();
  delay_line_param_if #(.DWIDTH(8), .MAX_DELAY(M2)) b2 ();

  delay_line_param #(.DWIDTH(8), .MAX_DELAY(M1)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(b1)
  );
  delay_line_param #(.DWIDTH(8), .MAX_DELAY(M2)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: queue of accepted samples, newest first, pre-filled with zeros
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];
  int         f1;
  int         f2;

  function automatic void m_reset1();
    q1.delete();
    for (int i = 0; i < M1; i++) q1.push_back(8'h00);
    f1 = 0;
  endfunction

  function automatic void m_reset2();
    q2.delete();
    for (int i = 0; i < M2; i++) q2.push_back(8'h00);
    f2 = 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset1();
      m_reset2();
    end else begin
      if (b1.clr_i) m_reset1();
      else if (b1.en_i) begin
        q1.push_front(b1.data_i);
        void'(q1.pop_back());
        if (f1 < M1) f1++;
      end
      if (b2.clr_i) m_reset2();
      else if (b2.en_i) begin
        q2.push_front(b2.data_i);
        void'(q2.pop_back());
        if (f2 < M2) f2++;
      end
    end
  end

  function automatic int deff1();
    return (int'(b1.delay_i) > M1) ? M1 : int'(b1.delay_i);
  endfunction
  function automatic int deff2();
    return (int'(b2.delay_i) > M2) ? M2 : int'(b2.delay_i);
  endfunction
  function automatic logic [7:0] e_data1();
    if (deff1() == 0) return b1.data_i;
    return q1[deff1()-1];
  endfunction
  function automatic logic [7:0] e_data2();
    if (deff2() == 0) return b2.data_i;
    return q2[deff2()-1];
  endfunction
  function automatic logic e_valid1();
    return f1 >= deff1();
  endfunction
  function automatic logic e_valid2();
    return f2 >= deff2();
  endfunction
  function automatic logic e_err1();
    return int'(b1.delay_i) > M1;
  endfunction
  function automatic logic e_err2();
    return int'(b2.delay_i) > M2;
  endfunction

  task automatic set_in(input logic en, input logic clr, input logic [7:0] d,
                        input logic [4:0] dl1, input logic [4:0] dl2);
    b1.en_i = en;  b1.clr_i = clr; b1.data_i = d; b1.delay_i = dl1;
    b2.en_i = en;  b2.clr_i = clr; b2.data_i = d; b2.delay_i = dl2;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_reset1();
    m_reset2();
    set_in(1'b1, 1'b0, 8'h3C, 5'd5, 5'd25);
    repeat (2) @(posedge clk);
    #3;
    if (b1.data_o !== 8'h00) begin errors++; $display("FAIL rst_data1 got %h exp 00", b1.data_o); end
    checks++;
    if (b1.valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid1 got %b exp 0", b1.valid_o); end
    checks++;
    if (b1.delay_err_o !== 1'b0) begin errors++; $display("FAIL rst_err1 got %b exp 0", b1.delay_err_o); end
    checks++;
    if (b2.delay_err_o !== 1'b1) begin errors++; $display("FAIL rst_err2 got %b exp 1", b2.delay_err_o); end
    checks++;
    if (b2.data_o !== 8'h00 || b2.valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_out2 got %h/%b exp 00/0", b2.data_o, b2.valid_o);
    end
    checks++;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      set_in(1'b1, 1'b0, d, 5'd0, 5'd0);
      #1;
      if (b1.data_o !== d || b1.valid_o !== 1'b1) begin
        errors++; $display("FAIL rst_pass got %h/%b exp %h/1", b1.data_o, b1.valid_o, d);
      end
      checks++;
    end
  endtask

  task automatic test_basic();
    set_in(1'b1, 1'b0, 8'd1, 5'd5, 5'd5);
    #2 rst_n = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      logic [7:0] exp_d;
      logic       exp_v;
      set_in(1'b1, 1'b0, 8'(n), 5'd5, 5'd5);
      tick();
      exp_d = (n < 5) ? 8'h00 : 8'(n - 4);
      exp_v = (n >= 5);
      if (b1.data_o !== exp_d) begin errors++; $display("FAIL basic_data e%0d got %h exp %h", n, b1.data_o, exp_d); end
      checks++;
      if (b1.valid_o !== exp_v) begin errors++; $display("FAIL basic_valid e%0d got %b exp %b", n, b1.valid_o, exp_v); end
      checks++;
    end
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      set_in(1'($urandom), 1'b0, d, 5'd0, 5'd0);
      #1;
      if (b1.data_o !== d) begin errors++; $display("FAIL pass_data got %h exp %h", b1.data_o, d); end
      checks++;
      if (b1.valid_o !== 1'b1) begin errors++; $display("FAIL pass_valid got %b exp 1", b1.valid_o); end
      checks++;
      tick();
    end
  endtask

  task automatic test_enable_gaps();
    logic en_pat [7];
    en_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    set_in(1'b1, 1'b1, 8'hFF, 5'd3, 5'd3);
    tick();
    for (int i = 0; i < 7; i++) begin
      set_in(en_pat[i], 1'b0, 8'(8'hA1 + i), 5'd3, 5'd3);
      tick();
      if (i == 4 && b1.data_o !== 8'hA1) begin
        errors++; $display("FAIL gap_first got %h exp a1", b1.data_o);
      end
      if (i == 4) checks++;
      if (b1.data_o !== e_data1() || b1.valid_o !== e_valid1()) begin
        errors++; $display("FAIL gap_model e%0d got %h/%b exp %h/%b", i, b1.data_o, b1.valid_o, e_data1(), e_valid1());
      end
      checks++;
    end
  endtask

  task automatic test_delay_change();
    set_in(1'b1, 1'b1, 8'h00, 5'd4, 5'd4);
    tick();
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 1'b0, 8'($urandom), 5'd4, 5'd4);
      tick();
      if (b1.data_o !== e_data1() || b1.valid_o !== e_valid1()) begin
        errors++; $display("FAIL chg_prime got %h/%b exp %h/%b", b1.data_o, b1.valid_o, e_data1(), e_valid1());
      end
      checks++;
    end
    b1.delay_i = 5'd10;
    #1;
    if (b1.valid_o !== 1'b0) begin errors++; $display("FAIL chg_drop got %b exp 0", b1.valid_o); end
    checks++;
    for (int i = 1; i <= 5; i++) begin
      set_in(1'b1, 1'b0, 8'($urandom), 5'd10, 5'd10);
      tick();
      if (b1.valid_o !== (6 + i >= 10)) begin
        errors++; $display("FAIL chg_rise e%0d got %b exp %b", i, b1.valid_o, (6 + i >= 10));
      end
      checks++;
      if (b1.data_o !== e_data1()) begin errors++; $display("FAIL chg_data got %h exp %h", b1.data_o, e_data1()); end
      checks++;
    end
    b1.delay_i = 5'd2;
    #1;
    if (b1.valid_o !== 1'b1) begin errors++; $display("FAIL chg_lower_valid got %b exp 1", b1.valid_o); end
    checks++;
    if (b1.data_o !== q1[1]) begin errors++; $display("FAIL chg_lower_data got %h exp %h", b1.data_o, q1[1]); end
    checks++;
  endtask

  task automatic test_clamp();
    set_in(1'b1, 1'b1, 8'h00, 5'd7, 5'd25);
    tick();
    for (int i = 0; i < 30; i++) begin
      set_in(($urandom % 4) != 0, 1'b0, 8'($urandom), 5'd7, 5'd25);
      tick();
      if (b2.delay_err_o !== 1'b1) begin errors++; $display("FAIL clamp_err got %b exp 1", b2.delay_err_o); end
      checks++;
      if (b2.data_o !== e_data2() || b2.valid_o !== e_valid2()) begin
        errors++; $display("FAIL clamp_model got %h/%b exp %h/%b", b2.data_o, b2.valid_o, e_data2(), e_valid2());
      end
      checks++;
    end
    b2.delay_i = 5'd20;
    #1;
    if (b2.delay_err_o !== 1'b0) begin errors++; $display("FAIL clamp_err20 got %b exp 0", b2.delay_err_o); end
    checks++;
    if (b2.data_o !== q2[19] || b2.valid_o !== (f2 >= 20)) begin
      errors++; $display("FAIL clamp_d20 got %h/%b exp %h/%b", b2.data_o, b2.valid_o, q2[19], (f2 >= 20));
    end
    checks++;
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 1'b0, 8'($urandom), 5'd7, 5'd7);
      tick();
    end
    if (b1.valid_o !== 1'b1) begin errors++; $display("FAIL flush_primed got %b exp 1", b1.valid_o); end
    checks++;
    set_in(1'b1, 1'b1, 8'h5A, 5'd7, 5'd7);
    tick();
    if (b1.data_o !== 8'h00 || b1.valid_o !== 1'b0) begin
      errors++; $display("FAIL flush_state got %h/%b exp 00/0", b1.data_o, b1.valid_o);
    end
    checks++;
    for (int i = 1; i <= 7; i++) begin
      set_in(1'b1, 1'b0, 8'(8'h10 + i), 5'd7, 5'd7);
      tick();
      if (b1.valid_o !== (i == 7)) begin errors++; $display("FAIL flush_refill e%0d got %b exp %b", i, b1.valid_o, (i == 7)); end
      checks++;
    end
    if (b1.data_o !== 8'h11) begin errors++; $display("FAIL flush_discard got %h exp 11", b1.data_o); end
    checks++;
    set_in(1'b0, 1'b0, 8'h77, 5'd7, 5'd7);
    #1 rst_n = 1'b0;
    #1;
    if (b1.data_o !== 8'h00 || b1.valid_o !== 1'b0) begin
      errors++; $display("FAIL async_rst got %h/%b exp 00/0", b1.data_o, b1.valid_o);
    end
    checks++;
    if (b2.data_o !== 8'h00 || b2.valid_o !== 1'b0) begin
      errors++; $display("FAIL async_rst2 got %h/%b exp 00/0", b2.data_o, b2.valid_o);
    end
    checks++;
    #1 rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int t = 0; t < 50; t++) begin
      logic [4:0] dl;
      int         len;
      dl  = 5'($urandom);
      len = 5 + int'($urandom % 36);
      for (int c = 0; c < len; c++) begin
        if (($urandom % 8) == 0) dl = 5'($urandom);
        set_in(($urandom % 4) != 0, ($urandom % 25) == 0, 8'($urandom), dl, dl);
        #1;
        if (b1.data_o !== e_data1() || b1.valid_o !== e_valid1() || b1.delay_err_o !== e_err1()) begin
          errors++; $display("FAIL rnd1 t%0d c%0d got %h/%b/%b exp %h/%b/%b", t, c,
            b1.data_o, b1.valid_o, b1.delay_err_o, e_data1(), e_valid1(), e_err1());
        end
        checks++;
        if (b2.data_o !== e_data2() || b2.valid_o !== e_valid2() || b2.delay_err_o !== e_err2()) begin
          errors++; $display("FAIL rnd2 t%0d c%0d got %h/%b/%b exp %h/%b/%b", t, c,
            b2.data_o, b2.valid_o, b2.delay_err_o, e_data2(), e_valid2(), e_err2());
        end
        checks++;
        if (($urandom % 60) == 0) begin
          #1 rst_n = 1'b0;
          #1 rst_n = 1'b1;
        end
        tick();
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    m_reset1();
    m_reset2();
    test_reset();
    test_basic();
    test_passthrough();
    test_enable_gaps();
    test_delay_change();
    test_clamp();
    test_flush_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
